cpu_seq_ctrl: RTL
=================

# cpu_seq_ctrl

Instruction-cycle controller for the CPU, sitting on the consuming end of the sequence counter (SC). It reads the SC step value, decodes it into timing signals, and steps a fetch/decode/execute FSM. It drives SC increment and clear back to the SC, issues memory, PC, IR and AC strobes, stalls on memory, and handles halt and error conditions.

## Interface
Parameters:
- SC_W, 8, width of the SC step value.
- OP_W, 4, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sc_count  in  SC_W  current SC value (SC `data_out`).
- start  in  1  begin or resume execution from IDLE or HALT.
- halt_req  in  1  request halt at the next instruction boundary.
- ir_opcode  in  OP_W  opcode field of the IR, valid from T2 onward.
- mem_ready  in  1  memory access completes this cycle.
- sc_inc  out  1  SC increment request.
- sc_clr  out  1  SC synchronous clear request; has priority over sc_inc in the SC.
- t_step  out  8  one-hot timing T0..T7 from sc_count.
- phase  out  2  0 IDLE/HALT, 1 FETCH, 2 DECODE, 3 EXEC.
- mem_rd, mem_wr  out  1  memory strobes, held until mem_ready.
- ld_ir, pc_inc, pc_ld, ac_ld, alu_en  out  1  datapath strobes.
- halted  out  1  registered; high in HALT.
- illegal_op  out  1  registered, sticky; an undefined opcode was seen.
- seq_err  out  1  registered, sticky; sc_count was at or above 8 outside IDLE/HALT.

## Operation
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT. Reset enters IDLE.
- Strobes, sc_inc, sc_clr, t_step and phase are combinational from the state and sc_count. halted, illegal_op and seq_err are registered.
- IDLE: sc_clr=1. When start=1, go to FETCH on the next edge.
- FETCH:
  - T0: mem_rd=1. sc_inc=mem_ready.
  - T1: ld_ir=1, pc_inc=1, sc_inc=1. Go to DECODE.
- DECODE, T2: sc_inc=1. Go to EXEC.
- EXEC, by ir_opcode:
  - 0x0 NOP: T3 sc_clr.
  - 0x1 LOAD: T3 mem_rd, sc_inc=mem_ready. T4 ac_ld, sc_clr.
  - 0x2 STORE: T3 mem_wr; when mem_ready, sc_clr.
  - 0x3 ADD: T3 mem_rd, sc_inc=mem_ready. T4 alu_en, ac_ld, sc_clr.
  - 0x4 JMP: T3 pc_ld, sc_clr.
  - 0xF HLT: T3 sc_clr. Go to HALT.
  - Any other opcode: T3 sc_clr, set illegal_op, go to FETCH.
- Instruction boundary: any EXEC cycle with sc_clr=1.
  - If halt_req=1 there, go to HALT; otherwise go to FETCH.
  - halt_req at any other time is ignored.
- HALT: sc_clr=1, halted=1. When start=1, go to FETCH.
- Decode error: in FETCH/DECODE/EXEC, if sc_count ≥ 8 or does not match the expected step for the state:
  - sc_clr=1, all other strobes 0.
  - Set seq_err and go to FETCH.
- Only one of sc_inc and sc_clr is ever high.
- t_step is 0 when sc_count ≥ 8.

## Timing
- After reset: state IDLE, halted=0, illegal_op=0, seq_err=0, sc_clr=1. All other outputs are 0; t_step reflects sc_count.
- An asynchronous rst assertion mid-instruction returns to IDLE immediately. Strobes drop in the same cycle and the sticky flags clear.
- The SC responds one cycle after sc_inc or sc_clr. The controller never assumes a step has advanced before sc_count shows it.
- Latency with mem_ready tied high: NOP/JMP/STORE/HLT take 4 cycles, LOAD/ADD take 5.
- Each low cycle of mem_ready in T0 or T3 adds one cycle. mem_rd/mem_wr stay asserted throughout the wait.
- start during FETCH/DECODE/EXEC is ignored.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_JMP, OP_HLT;
  - the FSM state encoding;
  - the phase encoding.
- Sub-module t_decode: combinational sc_count → one-hot t_step, plus a valid flag for sc_count < 8. The bench reuses it.
- The bench pairs cpu_seq_ctrl with the existing SC, or an SC model with the same inc/clr contract.

## Test plan
- Reset, then start with opcode 0x0 and mem_ready=1 → sc_count sequence 0,1,2,3,0. sc_clr at T3. phase 1,1,2,3,1.
- LOAD with mem_ready low for 3 cycles at T3 → mem_rd high for 4 cycles. ac_ld at T4. Total 8 cycles.
- halt_req pulse at T1 of ADD → ignored. halt_req high at the T4 boundary of ADD → HALT, halted=1, sc_clr held. start then gives fetch T0 next cycle.
- Opcode 0x9 → illegal_op=1 after T3, next fetch proceeds. Opcode 0xF → halted=1 after 4 cycles.
- Force sc_count=0x0A during EXEC → t_step=0, sc_clr=1, seq_err=1, return to FETCH.
- Assert rst at T3 of STORE with mem_wr high → mem_wr=0 and state IDLE in the same cycle; flags cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction-cycle controller:
// opcodes, FSM state encoding and the phase encoding.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_HLT   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_FETCH  = 2'd1,
    PH_DECODE = 2'd2,
    PH_EXEC   = 2'd3
  } phase_t;

endpackage

// File: rtl/t_decode.sv
// Sequence-counter step decoder: one-hot T0..T7 plus a flag that the
// step value lies inside the decodable range.
module t_decode #(
  parameter int SC_W = 8
) (
  input  logic [SC_W-1:0] sc_count,
  output logic [7:0]      t_step,
  output logic            valid
);

  // one-hot decode, all-zero when the step is out of range
  always_comb begin
    valid  = (sc_count < SC_W'(8));
    t_step = 8'd0;
    if (valid) begin
      t_step = 8'd1 << sc_count[2:0];
    end else begin
      t_step = 8'd0;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer driven by the sequence counter value;
// issues SC inc/clr, memory and datapath strobes, handles halt and errors.
module cpu_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int SC_W = 8,
  parameter int OP_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SC_W-1:0] sc_count,
  input  logic            start,
  input  logic            halt_req,
  input  logic [OP_W-1:0] ir_opcode,
  input  logic            mem_ready,
  output logic            sc_inc,
  output logic            sc_clr,
  output logic [7:0]      t_step,
  output logic [1:0]      phase,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            ld_ir,
  output logic            pc_inc,
  output logic            pc_ld,
  output logic            ac_ld,
  output logic            alu_en,
  output logic            halted,
  output logic            illegal_op,
  output logic            seq_err
);

  state_t     state_r;
  state_t     state_nx_s;
  phase_t     phase_s;
  logic [7:0] t_step_s;
  logic       t_valid_s;
  logic       boundary_s;
  logic       ill_set_s;
  logic       seq_set_s;
  logic       halted_r;
  logic       illegal_r;
  logic       seq_err_r;

  t_decode #(.SC_W(SC_W)) u_t_decode (
    .sc_count (sc_count),
    .t_step   (t_step_s),
    .valid    (t_valid_s)
  );

  // next-state and strobe decode from state, step and opcode
  always_comb begin
    state_nx_s = state_r;
    phase_s    = PH_IDLE;
    sc_inc     = 1'b0;
    sc_clr     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ld_ir      = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    ac_ld      = 1'b0;
    alu_en     = 1'b0;
    boundary_s = 1'b0;
    ill_set_s  = 1'b0;
    seq_set_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        sc_clr = 1'b1;
        if (start) state_nx_s = ST_FETCH;
        else       state_nx_s = ST_IDLE;
      end
      ST_FETCH: begin
        phase_s = PH_FETCH;
        if (t_step_s[0]) begin
          mem_rd = 1'b1;
          sc_inc = mem_ready;
        end else if (t_step_s[1]) begin
          ld_ir      = 1'b1;
          pc_inc     = 1'b1;
          sc_inc     = 1'b1;
          state_nx_s = ST_DECODE;
        end else begin
          seq_set_s = 1'b1;
        end
      end
      ST_DECODE: begin
        phase_s = PH_DECODE;
        if (t_step_s[2]) begin
          sc_inc     = 1'b1;
          state_nx_s = ST_EXEC;
        end else begin
          seq_set_s = 1'b1;
        end
      end
      ST_EXEC: begin
        phase_s = PH_EXEC;
        if (t_step_s[3]) begin
          case (ir_opcode)
            OP_NOP: boundary_s = 1'b1;
            OP_LOAD, OP_ADD: begin
              mem_rd = 1'b1;
              sc_inc = mem_ready;
            end
            OP_STORE: begin
              mem_wr     = 1'b1;
              boundary_s = mem_ready;
            end
            OP_JMP: begin
              pc_ld      = 1'b1;
              boundary_s = 1'b1;
            end
            OP_HLT: boundary_s = 1'b1;
            default: begin
              ill_set_s  = 1'b1;
              boundary_s = 1'b1;
            end
          endcase
        end else if (t_step_s[4] && (ir_opcode == OP_LOAD || ir_opcode == OP_ADD)) begin
          ac_ld      = 1'b1;
          alu_en     = (ir_opcode == OP_ADD);
          boundary_s = 1'b1;
        end else begin
          seq_set_s = 1'b1;
        end
        // an HLT at its boundary halts regardless of halt_req
        if (boundary_s) begin
          sc_clr = 1'b1;
          if (halt_req || ir_opcode == OP_HLT) state_nx_s = ST_HALT;
          else                                 state_nx_s = ST_FETCH;
        end else begin
          sc_clr = 1'b0;
        end
      end
      ST_HALT: begin
        sc_clr = 1'b1;
        if (start) state_nx_s = ST_FETCH;
        else       state_nx_s = ST_HALT;
      end
      default: begin
        sc_clr     = 1'b1;
        state_nx_s = ST_IDLE;
      end
    endcase

    // a bad step overrides every strobe and restarts the fetch
    if (seq_set_s) begin
      sc_inc     = 1'b0;
      sc_clr     = 1'b1;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ld_ir      = 1'b0;
      pc_inc     = 1'b0;
      pc_ld      = 1'b0;
      ac_ld      = 1'b0;
      alu_en     = 1'b0;
      ill_set_s  = 1'b0;
      state_nx_s = ST_FETCH;
    end else begin
      seq_set_s = 1'b0;
    end
  end

  // state register and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
      seq_err_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      halted_r  <= (state_nx_s == ST_HALT);
      illegal_r <= illegal_r | ill_set_s;
      seq_err_r <= seq_err_r | seq_set_s;
    end
  end

  assign t_step     = t_step_s;
  assign phase      = phase_s;
  assign halted     = halted_r;
  assign illegal_op = illegal_r;
  assign seq_err    = seq_err_r;

endmodule
